// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: latch enables/flushes,
// operand forwarding selects, data-memory wait tracking with timeout halt.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          timeout_nxt;
  logic          lu;

  always_comb begin
    lu = idex_mem_read && (idex_rd != 5'd0) &&
         ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
          (id_uses_rs2 && (id_rs2 == idex_rd)));
  end

  // Freeze outranks branch so a branch held in EX redirects only once memory is ready.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_en    = 1'b0;
    idex_flush = 1'b1;
    exmem_en   = 1'b0;
    if (reset_n) begin
      if (state == HALT || dmem_busy) begin
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end else if (branch_taken) begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end else if (lu) begin
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reset_n) begin
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)
        fwd_a = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1)
        fwd_a = 2'b01;
      if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)
        fwd_b = 2'b10;
      else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2)
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    timeout_nxt = mem_timeout;
    unique case (state)
      RUN: begin
        if (dmem_busy) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (!dmem_busy) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WW'(MAX_WAIT)) begin
          state_nxt   = HALT;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      HALT: begin
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
      if (state != HALT && !pc_en && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_comb halted = (state == HALT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared every cycle against a priority-rule reference model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MW = 4;
  localparam int unsigned CW = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [4:0]    id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic          id_uses_rs1, id_uses_rs2, idex_mem_read, exmem_reg_write;
  logic          memwb_reg_write, branch_taken, dmem_busy;
  logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [1:0]    fwd_a, fwd_b;
  logic          mem_timeout, halted;
  logic [CW-1:0] stall_cycles;

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .halted(halted), .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: length of the current busy run, halt/timeout flags, stall count.
  int busy_run;
  bit m_halt, m_to;
  int m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_sel(input logic [4:0] rs);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return 2;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    busy_run = 0; m_halt = 0; m_to = 0; m_stalls = 0;
  endtask

  task automatic set_idle();
    reset_n = 1'b1;
    id_rs1 = '0; id_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
    exmem_rd = '0; memwb_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_lu();
    idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  // Inputs are set just after a posedge; check outputs mid-cycle, then advance one edge.
  task automatic step();
    bit lu;
    bit [5:0] ctl;
    int fa, fb;
    #2;
    lu = idex_mem_read && idex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
    // ctl order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en
    if (!reset_n)                 ctl = 6'b001010;
    else if (m_halt || dmem_busy) ctl = 6'b000000;
    else if (branch_taken)        ctl = 6'b111111;
    else if (lu)                  ctl = 6'b000111;
    else                          ctl = 6'b110101;
    fa = reset_n ? fwd_sel(idex_rs1) : 0;
    fb = reset_n ? fwd_sel(idex_rs2) : 0;
    check("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}), 32'(ctl));
    check("fwd_a", 32'(fwd_a), 32'(fa));
    check("fwd_b", 32'(fwd_b), 32'(fb));
    check("mem_timeout", 32'(mem_timeout), 32'(m_to));
    check("halted", 32'(halted), 32'(m_halt));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    @(posedge clock);
    if (!reset_n) model_reset();
    else if (!m_halt) begin
      if (!ctl[5] && m_stalls < 2**CW - 1) m_stalls++;
      if (dmem_busy) begin
        busy_run++;
        if (busy_run > MW) begin m_halt = 1; m_to = 1; end
      end else busy_run = 0;
    end
    #1;
  endtask

  int s0;
  bit was_busy;

  initial begin
    set_idle();
    reset_n = 1'b0;
    @(posedge clock); #1;
    model_reset();
    step();                                // reset outputs while reset_n low
    set_idle();

    // Load-use: one bubble, then the bubble is in ID/EX and the pipe runs normally.
    set_lu(); step();
    check("t1_pc_en_stall", 32'(pc_en), 32'd0);
    idex_mem_read = 1'b0; step();
    check("t1_pc_en_after", 32'(pc_en), 32'd1);
    check("t1_stall_cnt", 32'(stall_cycles), 32'd1);

    // rd=0 load never stalls; x0 never forwarded.
    set_idle(); set_lu(); idex_rd = 5'd0; id_rs1 = 5'd0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; step();
    check("t2_no_stall", 32'(pc_en), 32'd1);
    check("t2_fwd_x0", 32'(fwd_a), 32'd0);

    // EX/MEM beats MEM/WB; MEM/WB when EX/MEM does not write.
    set_idle(); idex_rs1 = 5'd7; exmem_rd = 5'd7; memwb_rd = 5'd7;
    exmem_reg_write = 1'b1; memwb_reg_write = 1'b1; step();
    check("t3_fwd_exmem", 32'(fwd_a), 32'd2);
    exmem_reg_write = 1'b0; step();
    check("t3_fwd_memwb", 32'(fwd_a), 32'd1);

    // Branch + load-use held through a 3-cycle freeze; redirect fires after.
    set_idle(); s0 = int'(stall_cycles);
    set_lu(); branch_taken = 1'b1; dmem_busy = 1'b1;
    repeat (3) step();
    dmem_busy = 1'b0; step();
    check("t4_redirect", 32'({pc_en, ifid_flush, idex_flush}), 32'b111);
    check("t4_stall_delta", 32'(int'(stall_cycles) - s0), 32'd3);

    // MAX_WAIT busy cycles is tolerated; MAX_WAIT+1 halts.
    set_idle(); dmem_busy = 1'b1;
    repeat (MW) step();
    dmem_busy = 1'b0; step();
    check("t5_no_timeout", 32'({mem_timeout, halted}), 32'b00);
    dmem_busy = 1'b1;
    repeat (10) step();
    check("t5_timeout", 32'({mem_timeout, halted}), 32'b11);
    s0 = int'(stall_cycles);
    dmem_busy = 1'b0; set_lu(); repeat (3) step();
    check("t5_halt_hold", 32'({mem_timeout, halted}), 32'b11);
    check("t5_stall_frozen", 32'(stall_cycles), 32'(s0));

    // Reset mid-wait clears the wait count and counters.
    set_idle(); reset_n = 1'b0; step();
    reset_n = 1'b1; dmem_busy = 1'b1; repeat (2) step();
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    check("t6_stall_clr", 32'(stall_cycles), 32'd0);
    repeat (MW) step();
    dmem_busy = 1'b0; step();
    check("t6_wait_clr", 32'(halted), 32'd0);

    // Stall counter saturation.
    set_idle(); set_lu(); repeat (70) step();
    check("sat", 32'(stall_cycles), 32'(2**CW - 1));

    // Random traffic with bursty dmem_busy and occasional reset.
    was_busy = 0;
    repeat (3000) begin
      reset_n         = ($urandom_range(0, 59) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      idex_rs1        = 5'($urandom_range(0, 3));
      idex_rs2        = 5'($urandom_range(0, 3));
      idex_rd         = 5'($urandom_range(0, 3));
      exmem_rd        = 5'($urandom_range(0, 3));
      memwb_rd        = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      idex_mem_read   = 1'($urandom_range(0, 1));
      exmem_reg_write = 1'($urandom_range(0, 1));
      memwb_reg_write = 1'($urandom_range(0, 1));
      branch_taken    = ($urandom_range(0, 4) == 0);
      dmem_busy       = was_busy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      was_busy        = dmem_busy;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
